memory_arbiter: RTL and testbench

- Shares one single-port memory interface between the instruction-fetch requester (I) and the execute-stage load/store requester (D).
- Captures pulse requests into per-requester pending buffers and issues one transaction at a time downstream.
- Routes mem_ready/mem_rdata back to the owning requester.
- Supports an instruction-side flush for branch/trap redirect. It discards a pending fetch and suppresses the response of an in-flight fetch.

---
 rtl/memory_arbiter_if.sv | 42 ++++
 rtl/memory_arbiter.sv | 145 ++++++++++++++
 tb/tb_memory_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters,
// the arbiter and the single-port downstream memory.
interface memory_arbiter_if #(
    parameter int XLEN = 32
);
    logic                i_valid;
    logic [XLEN-1:0]     i_addr;
    logic                i_flush;
    logic                i_ready;
    logic [XLEN-1:0]     i_rdata;
    logic                d_valid;
    logic [XLEN-1:0]     d_addr;
    logic [XLEN-1:0]     d_wdata;
    logic [XLEN/8-1:0]   d_wstrb;
    logic                d_ready;
    logic [XLEN-1:0]     d_rdata;
    logic                mem_valid;
    logic                mem_instr;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_wstrb;
    logic                mem_ready;
    logic [XLEN-1:0]     mem_rdata;

    modport slave (
        input  i_valid, i_addr, i_flush,
        input  d_valid, d_addr, d_wdata, d_wstrb,
        input  mem_ready, mem_rdata,
        output i_ready, i_rdata, d_ready, d_rdata,
        output mem_valid, mem_instr, mem_addr,
        output mem_wdata, mem_wstrb
    );

    modport master (
        output i_valid, i_addr, i_flush,
        output d_valid, d_addr, d_wdata, d_wstrb,
        output mem_ready, mem_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata,
        input  mem_valid, mem_instr, mem_addr,
        input  mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between instruction fetch
// and load/store, one outstanding transaction at a time.
module memory_arbiter #(
    parameter int XLEN = 32,
    parameter bit RR   = 1'b0
) (
    input logic             clk,
    input logic             rst,
    memory_arbiter_if.slave bus
);
    localparam int SW = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_e;

    state_e          state_q, state_d;
    logic            ipend_q, ipend_d;
    logic            dpend_q, dpend_d;
    logic            drop_q, drop_d;
    logic            last_q, last_d;
    logic [XLEN-1:0] iaddr_q, iaddr_d;
    logic [XLEN-1:0] daddr_q, daddr_d;
    logic [XLEN-1:0] dwdata_q, dwdata_d;
    logic [SW-1:0]   dwstrb_q, dwstrb_d;
    logic            mem_instr_q, mem_instr_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic            fetch_ok;
    logic            pick_d;
    logic            issue;

    always_comb begin
        // a flush this cycle kills the pending fetch before issue
        fetch_ok = ipend_q & ~bus.i_flush;
        if (dpend_q && fetch_ok) begin
            pick_d = RR ? ~last_q : 1'b1;
        end else begin
            pick_d = dpend_q;
        end
        issue = (state_q == IDLE) & (dpend_q | fetch_ok);

        state_d     = state_q;
        ipend_d     = ipend_q;
        dpend_d     = dpend_q;
        drop_d      = drop_q;
        last_d      = last_q;
        iaddr_d     = iaddr_q;
        daddr_d     = daddr_q;
        dwdata_d    = dwdata_q;
        dwstrb_d    = dwstrb_q;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d     = pick_d ? BUSY_D : BUSY_I;
                    last_d      = pick_d;
                    mem_instr_d = ~pick_d;
                    mem_addr_d  = pick_d ? daddr_q : iaddr_q;
                    mem_wdata_d = pick_d ? dwdata_q : '0;
                    mem_wstrb_d = pick_d ? dwstrb_q : '0;
                    if (pick_d) dpend_d = 1'b0;
                    else        ipend_d = 1'b0;
                end
            end
            BUSY_I: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else if (bus.i_flush) begin
                    drop_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (bus.mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.i_flush) ipend_d = 1'b0;
        if (bus.i_valid) begin
            ipend_d = 1'b1;
            iaddr_d = bus.i_addr;
        end
        if (bus.d_valid) begin
            dpend_d  = 1'b1;
            daddr_d  = bus.d_addr;
            dwdata_d = bus.d_wdata;
            dwstrb_d = bus.d_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ipend_q     <= 1'b0;
            dpend_q     <= 1'b0;
            drop_q      <= 1'b0;
            last_q      <= 1'b0;
            iaddr_q     <= '0;
            daddr_q     <= '0;
            dwdata_q    <= '0;
            dwstrb_q    <= '0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            ipend_q     <= ipend_d;
            dpend_q     <= dpend_d;
            drop_q      <= drop_d;
            last_q      <= last_d;
            iaddr_q     <= iaddr_d;
            daddr_q     <= daddr_d;
            dwdata_q    <= dwdata_d;
            dwstrb_q    <= dwstrb_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign bus.mem_valid = rst & issue;
    assign bus.mem_instr = issue ? mem_instr_d : mem_instr_q;
    assign bus.mem_addr  = issue ? mem_addr_d  : mem_addr_q;
    assign bus.mem_wdata = issue ? mem_wdata_d : mem_wdata_q;
    assign bus.mem_wstrb = issue ? mem_wstrb_d : mem_wstrb_q;

    assign bus.d_ready = rst & bus.mem_ready
                       & (state_q == BUSY_D);
    assign bus.i_ready = rst & bus.mem_ready
                       & (state_q == BUSY_I) & ~drop_q;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_memory_arbiter;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        t_iv = 0, t_fl = 0, t_dv = 0, t_mr = 0;
    logic [31:0] t_ia = 0, t_da = 0, t_dw = 0, t_mrd = 0;
    logic [3:0]  t_ds = 0;

    memory_arbiter_if #(.XLEN(XLEN)) bus0 ();
    memory_arbiter_if #(.XLEN(XLEN)) bus1 ();

    assign bus0.i_valid   = !sel & t_iv;
    assign bus0.i_flush   = !sel & t_fl;
    assign bus0.d_valid   = !sel & t_dv;
    assign bus0.mem_ready = !sel & t_mr;
    assign bus0.i_addr    = t_ia;
    assign bus0.d_addr    = t_da;
    assign bus0.d_wdata   = t_dw;
    assign bus0.d_wstrb   = t_ds;
    assign bus0.mem_rdata = t_mrd;
    assign bus1.i_valid   = sel & t_iv;
    assign bus1.i_flush   = sel & t_fl;
    assign bus1.d_valid   = sel & t_dv;
    assign bus1.mem_ready = sel & t_mr;
    assign bus1.i_addr    = t_ia;
    assign bus1.d_addr    = t_da;
    assign bus1.d_wdata   = t_dw;
    assign bus1.d_wstrb   = t_ds;
    assign bus1.mem_rdata = t_mrd;

    memory_arbiter #(.XLEN(XLEN), .RR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    memory_arbiter #(.XLEN(XLEN), .RR(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    logic        o_mv, o_mi, o_ir, o_dr;
    logic [31:0] o_ma, o_mw, o_ird, o_drd;
    logic [3:0]  o_ms;
    assign o_mv  = sel ? bus1.mem_valid : bus0.mem_valid;
    assign o_mi  = sel ? bus1.mem_instr : bus0.mem_instr;
    assign o_ma  = sel ? bus1.mem_addr  : bus0.mem_addr;
    assign o_mw  = sel ? bus1.mem_wdata : bus0.mem_wdata;
    assign o_ms  = sel ? bus1.mem_wstrb : bus0.mem_wstrb;
    assign o_ir  = sel ? bus1.i_ready   : bus0.i_ready;
    assign o_dr  = sel ? bus1.d_ready   : bus0.d_ready;
    assign o_ird = sel ? bus1.i_rdata   : bus0.i_rdata;
    assign o_drd = sel ? bus1.d_rdata   : bus0.d_rdata;

    // reference model: owner 0 = none, 1 = fetch, 2 = data
    bit          m_ip, m_dp, m_drop, m_lastd;
    int          m_own;
    logic [31:0] m_ipa, m_dpa, m_dpw, m_ha, m_hw;
    logic [3:0]  m_dps, m_hs;
    bit          m_hi;
    bit          e_iss, e_ir, e_dr;
    int          dut_log[$];

    int passed = 0;
    int total  = 0;
    bit i_out, d_out;
    int wait_c;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h",
                    tag, obs, exp);
    endtask

    task automatic cyc(input logic r, input logic iv,
                       input logic [31:0] ia, input logic fl,
                       input logic dv, input logic [31:0] da,
                       input logic [31:0] dw,
                       input logic [3:0] ds, input logic mr,
                       input logic [31:0] mrd);
        bit ie, pd, rr;
        int own0;
        @(negedge clk);
        rst = r; t_iv = iv; t_ia = ia; t_fl = fl;
        t_dv = dv; t_da = da; t_dw = dw; t_ds = ds;
        t_mr = mr; t_mrd = mrd;
        #1;
        rr = sel;
        ie = m_ip && !fl;
        e_iss = r && m_own == 0 && (m_dp || ie);
        pd = m_dp && (!ie || !rr || !m_lastd);
        e_dr = r && mr && m_own == 2;
        e_ir = r && mr && m_own == 1 && !m_drop;
        chk("mem_valid", o_mv, e_iss);
        if (o_mv) dut_log.push_back(o_mi ? 1 : 2);
        if (e_iss) begin
            chk("iss_instr", o_mi, !pd);
            chk("iss_addr", o_ma, pd ? m_dpa : m_ipa);
            chk("iss_wdata", o_mw, pd ? m_dpw : 32'h0);
            chk("iss_wstrb", o_ms, pd ? m_dps : 4'h0);
        end else if (r && m_own != 0) begin
            chk("hold_instr", o_mi, m_hi);
            chk("hold_addr", o_ma, m_ha);
            chk("hold_wdata", o_mw, m_hw);
            chk("hold_wstrb", o_ms, m_hs);
        end
        chk("i_ready", o_ir, e_ir);
        chk("d_ready", o_dr, e_dr);
        if (e_ir) chk("i_rdata", o_ird, mrd);
        if (e_dr) chk("d_rdata", o_drd, mrd);
        if (!r) begin
            m_ip = 0; m_dp = 0; m_drop = 0; m_lastd = 0;
            m_own = 0; m_ipa = 0; m_dpa = 0; m_dpw = 0;
            m_dps = 0; m_ha = 0; m_hw = 0; m_hs = 0;
            m_hi = 0;
            return;
        end
        own0 = m_own;
        if (own0 != 0 && mr) begin
            m_own = 0;
            m_drop = 0;
        end else if (own0 == 1 && fl) begin
            m_drop = 1;
        end
        if (e_iss) begin
            m_own = pd ? 2 : 1;
            m_lastd = pd;
            m_hi = !pd;
            m_ha = pd ? m_dpa : m_ipa;
            m_hw = pd ? m_dpw : 32'h0;
            m_hs = pd ? m_dps : 4'h0;
            if (pd) m_dp = 0;
            else    m_ip = 0;
        end
        if (fl) m_ip = 0;
        if (iv) begin m_ip = 1; m_ipa = ia; end
        if (dv) begin
            m_dp = 1; m_dpa = da; m_dpw = dw; m_dps = ds;
        end
    endtask

    task automatic idle(input logic mr,
                        input logic [31:0] mrd);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, mr, mrd);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd(input int n);
        bit iv, dv, fl, mr;
        logic [3:0] ds;
        i_out = 0; d_out = 0; wait_c = 0;
        for (int k = 0; k < n; k++) begin
            iv = !i_out && ($urandom % 100) < 35;
            dv = !d_out && ($urandom % 100) < 35;
            fl = ($urandom % 100) < 8;
            ds = ($urandom % 2) ? 4'($urandom) : 4'h0;
            if (m_own != 0) begin
                wait_c--;
                mr = (wait_c == 0);
            end else begin
                mr = ($urandom % 100) < 5;
            end
            cyc(1, iv, $urandom, fl, dv, $urandom,
                $urandom, ds, mr, $urandom);
            if (e_iss) wait_c = $urandom_range(1, 3);
            if (e_ir) i_out = 0;
            if (e_dr) d_out = 0;
            if (fl) i_out = 0;
            if (iv) i_out = 1;
            if (dv) d_out = 1;
        end
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_mv", o_mv, 0);
        chk("rst_irdy", o_ir, 0);
        chk("rst_drdy", o_dr, 0);
        idle(1, 32'h1);
        chk("idle_stale_rdy", o_dr, 0);

        // single fetch
        cyc(1, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        chk("t1_mv", o_mv, 1);
        chk("t1_instr", o_mi, 1);
        chk("t1_addr", o_ma, 32'h8000_0000);
        idle(0, 0);
        idle(1, 32'h0000_0013);
        chk("t1_irdy", o_ir, 1);
        chk("t1_rdata", o_ird, 32'h0000_0013);
        chk("t1_drdy", o_dr, 0);
        idle(0, 0);

        // contention, fixed D priority
        dut_log.delete();
        cyc(1, 1, 32'h100, 0, 1, 32'h2000, 32'hCAFE_F00D,
            4'hF, 0, 0);
        idle(0, 0);
        chk("t2_d_first", o_mi, 0);
        idle(1, 32'h55);
        chk("t2_drdy", o_dr, 1);
        chk("t2_irdy0", o_ir, 0);
        idle(0, 0);
        chk("t2_i_addr", o_ma, 32'h100);
        idle(1, 32'h66);
        chk("t2_irdy", o_ir, 1);
        chk("t2_log_n", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            chk("t2_log0", dut_log[0], 2);
            chk("t2_log1", dut_log[1], 1);
        end

        // flush of an in-flight fetch
        cyc(1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);
        idle(1, 32'h77);
        chk("t4_dropped", o_ir, 0);
        cyc(1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        chk("t4_new_addr", o_ma, 32'h80);
        idle(1, 32'h88);
        chk("t4_irdy", o_ir, 1);

        // flush pending with a new fetch in the same cycle
        cyc(1, 0, 0, 0, 1, 32'h300, 0, 4'h0, 0, 0);
        cyc(1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_d_iss", o_mv, 1);
        cyc(1, 1, 32'h80, 1, 0, 0, 0, 0, 0, 0);
        idle(1, 32'h99);
        chk("t5_drdy", o_dr, 1);
        idle(0, 0);
        chk("t5_mv", o_mv, 1);
        chk("t5_addr", o_ma, 32'h80);
        idle(1, 32'hAA);
        chk("t5_irdy", o_ir, 1);
        idle(0, 0);
        chk("t5_no_more", o_mv, 0);

        // reset mid-transaction
        cyc(1, 0, 0, 0, 1, 32'h400, 32'h1234, 4'hF, 0, 0);
        idle(0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 32'hBB);
        chk("t6_mv", o_mv, 0);
        chk("t6_drdy", o_dr, 0);
        idle(0, 0);
        chk("t6_no_pend", o_mv, 0);

        rnd(300);

        // round-robin instance
        sel = 1'b1;
        do_reset();
        dut_log.delete();
        cyc(1, 1, 32'h1000, 0, 1, 32'h2000, 32'h5, 4'h3,
            0, 0);
        for (int k = 0; k < 6; k++) begin
            idle(0, 0);
            if (k % 2 == 0)
                cyc(1, 0, 0, 0, 1, 32'h2000 + 32'(k * 4),
                    32'(k), 4'h1, 1, 32'(k));
            else
                cyc(1, 1, 32'h1000 + 32'(k * 4), 0, 0, 0,
                    0, 0, 1, 32'(k));
        end
        chk("rr_log_n", dut_log.size(), 6);
        if (dut_log.size() == 6) begin
            for (int k = 0; k < 6; k++)
                chk("rr_order", dut_log[k],
                    (k % 2 == 0) ? 2 : 1);
        end
        do_reset();
        rnd(300);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
